// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// Holds the arbiter state encodings and the default values of the
// TIMEOUT and STARVE_MAX parameters used by the core.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY_IF = 2'b01,
    ST_BUSY_D  = 2'b10
  } arb_state_e;

  // Cycles a memory transaction may wait for mem_ack before it is aborted.
  localparam int TIMEOUT_DEFAULT    = 16;
  // Consecutive data grants allowed while a fetch is waiting.
  localparam int STARVE_MAX_DEFAULT = 3;

  // A fetch always reads a full word.
  localparam logic [3:0] FETCH_BE = 4'b1111;

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog for the memory port arbiter.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clear      : forces the count back to zero (held while the port is idle)
//   enable     : counts one cycle of waiting for mem_ack
//   expired    : high while the count sits at TIMEOUT-1
module arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a stalled enable can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between an instruction-fetch requester
// and a load/store requester.
// Ports:
//   clk, reset          : clock and asynchronous active-high reset
//   if_req/if_addr      : fetch request; if_ready/if_rdata complete it
//   d_req/d_we/d_be/
//   d_addr/d_wdata      : data request; d_ready/d_rdata complete it
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata : registered memory port
//   mem_rdata/mem_ack   : memory read data and completion
//   bus_err             : sticky flag, set when a transaction times out
// Data wins simultaneous requests, except that after STARVE_MAX consecutive
// data grants with a fetch waiting the fetch is granted.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  // starve_cnt is 2 bits wide, so STARVE_MAX must stay within 0..3.
  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  arb_state_e  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  starve_cnt_q, starve_cnt_d;
  logic        bus_err_q, bus_err_d;

  logic busy;
  logic wd_expired;
  logic finish;
  logic grant_data;

  assign busy   = (state_q != ST_IDLE);
  // Ack takes priority over an expiry landing in the same cycle.
  assign finish = busy && (mem_ack || wd_expired);

  // Counter runs only while waiting; it is held at zero in IDLE, which also
  // clears it on every grant.
  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!busy),
    .enable  (busy && !mem_ack),
    .expired (wd_expired)
  );

  assign grant_data = d_req && !(if_req && (starve_cnt_q == STARVE_LIM));

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    starve_cnt_d = starve_cnt_q;
    bus_err_d    = bus_err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          state_d     = ST_BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_be_d    = d_be;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (if_req && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 2'd1;
          end
        end else if (if_req) begin
          state_d      = ST_BUSY_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_be_d     = FETCH_BE;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          starve_cnt_d = '0;
        end
      end
      ST_BUSY_IF, ST_BUSY_D: begin
        if (finish) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          if (!mem_ack) begin
            bus_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      starve_cnt_q <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      starve_cnt_q <= starve_cnt_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_err   = bus_err_q;

  // Ready pulses are combinational in the completing cycle; a timeout
  // completes with zero data.
  assign if_ready = finish && (state_q == ST_BUSY_IF);
  assign d_ready  = finish && (state_q == ST_BUSY_D);
  assign if_rdata = (if_ready && mem_ack) ? mem_rdata : '0;
  assign d_rdata  = (d_ready && mem_ack) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int TIMEOUT    = 16;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .TIMEOUT    (TIMEOUT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .bus_err   (bus_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port (0 none, 1 fetch, 2 data), how many
  // busy cycles have elapsed, fairness count and the latched request.
  int          m_owner;
  int          m_age;
  int          m_starve;
  bit          m_err;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        last_ifr;
  logic        last_dr;
  int          txn = 0;

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        we;
    logic [3:0]  be;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [31:0] ack_data;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic        exp_d;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_age    = 0;
    m_starve = 0;
    m_err    = 1'b0;
    last_ifr = 1'b0;
    last_dr  = 1'b0;
  endtask

  // First half of a cycle: compare DUT outputs against the model.
  task automatic half_a();
    logic        done;
    logic [31:0] rd;
    @(negedge clk);
    done     = (m_owner != 0) && (mem_ack || (m_age == TIMEOUT - 1));
    rd       = (done && mem_ack) ? mem_rdata : 32'h0;
    last_ifr = done && (m_owner == 1);
    last_dr  = done && (m_owner == 2);
    chk("if_ready", 32'(if_ready), 32'(last_ifr));
    chk("d_ready", 32'(d_ready), 32'(last_dr));
    chk("if_rdata", if_rdata, last_ifr ? rd : 32'h0);
    chk("d_rdata", d_rdata, last_dr ? rd : 32'h0);
    chk("mem_req", 32'(mem_req), 32'(m_owner != 0));
    chk("bus_err", 32'(bus_err), 32'(m_err));
    if (m_owner != 0) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_be", 32'(mem_be), 32'(m_be));
      if (m_owner == 2) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (done) begin
      txn++;
      $display("txn %0d: %s addr=%h rdata=%h%s", txn, (m_owner == 1) ? "IF" : "D ",
               m_addr, rd, mem_ack ? "" : " timeout");
    end
  endtask

  // Second half: advance the model across the rising edge.
  task automatic half_b();
    @(posedge clk);
    if (m_owner == 0) begin
      if (d_req && !(if_req && m_starve == STARVE_MAX)) begin
        m_owner = 2;
        m_we    = d_we;
        m_be    = d_be;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_age   = 0;
        if (if_req) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      end else if (if_req) begin
        m_owner  = 1;
        m_we     = 1'b0;
        m_be     = 4'hF;
        m_addr   = if_addr;
        m_age    = 0;
        m_starve = 0;
      end
    end else if (last_ifr || last_dr) begin
      if (!mem_ack) m_err = 1'b1;
      m_owner = 0;
    end else begin
      m_age++;
    end
    #1;
  endtask

  task automatic cycle();
    half_a();
    half_b();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    if_req  = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = '0;
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] ord[8];
    int quiet;

    model_reset();

    // Table: single arbitration from a freshly reset arbiter.
    vecs[0] = '{1'b0, 1'b1, 1'b0, 4'b0011, 32'h0, 32'h0000_1000, 32'h0, 32'hCAFE_0001,
                1'b0, 4'b0011, 32'h0000_1000, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 4'b0001, 32'h0000_0040, 32'h0, 32'h0, 32'h0050_0093,
                1'b0, 4'b1111, 32'h0000_0040, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 4'b1111, 32'h0000_0080, 32'h0000_2000, 32'h0, 32'h1111_2222,
                1'b0, 4'b1111, 32'h0000_2000, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 4'b0100, 32'h0, 32'h0000_0102, 32'h00AB_0000, 32'h0,
                1'b1, 4'b0100, 32'h0000_0102, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 4'b0000, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'hFFFF_FFFF,
                1'b0, 4'b1111, 32'hFFFF_FFFC, 1'b0};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      if_req  = vecs[i].ireq;
      if_addr = vecs[i].iaddr;
      d_req   = vecs[i].dreq;
      d_we    = vecs[i].we;
      d_be    = vecs[i].be;
      d_addr  = vecs[i].daddr;
      d_wdata = vecs[i].wdata;
      cycle();
      mem_ack   = 1'b1;
      mem_rdata = vecs[i].ack_data;
      half_a();
      chk("vec_mem_req", 32'(mem_req), 32'h1);
      chk("vec_mem_addr", mem_addr, vecs[i].exp_addr);
      chk("vec_mem_we", 32'(mem_we), 32'(vecs[i].exp_we));
      chk("vec_mem_be", 32'(mem_be), 32'(vecs[i].exp_be));
      if (vecs[i].exp_d) chk("vec_mem_wdata", mem_wdata, vecs[i].wdata);
      chk("vec_d_ready", 32'(d_ready), 32'(vecs[i].exp_d));
      chk("vec_if_ready", 32'(if_ready), 32'(!vecs[i].exp_d));
      half_b();
      if_req  = 1'b0;
      d_req   = 1'b0;
      mem_ack = 1'b0;
      cycle();
    end

    // Fetch with ack arriving in the third busy cycle.
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    cycle();
    for (int k = 1; k <= 3; k++) begin
      mem_ack   = (k == 3);
      mem_rdata = (k == 3) ? 32'h0050_0093 : 32'hDEAD_BEEF;
      half_a();
      chk("fetch_ready", 32'(if_ready), 32'(k == 3));
      if (k == 3) chk("fetch_rdata", if_rdata, 32'h0050_0093);
      half_b();
    end
    if_req  = 1'b0;
    mem_ack = 1'b0;
    cycle();

    // Both requesters held continuously: D,D,D,IF repeating.
    do_reset();
    ord = '{32'hD000, 32'hD000, 32'hD000, 32'h1000, 32'hD000, 32'hD000, 32'hD000, 32'h1000};
    if_req  = 1'b1;
    if_addr = 32'h1000;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_be    = 4'hF;
    d_addr  = 32'hD000;
    for (int g = 0; g < 8; g++) begin
      mem_ack = 1'b0;
      cycle();
      mem_ack   = 1'b1;
      mem_rdata = 32'(g);
      half_a();
      chk($sformatf("grant_order_%0d", g), mem_addr, ord[g]);
      half_b();
    end
    if_req  = 1'b0;
    d_req   = 1'b0;
    mem_ack = 1'b0;
    cycle();

    // Watchdog: no ack ever, d_ready after 16 cycles with zero data.
    do_reset();
    d_req  = 1'b1;
    d_addr = 32'h0000_0200;
    cycle();
    for (int k = 1; k <= TIMEOUT; k++) begin
      half_a();
      chk("timeout_d_ready", 32'(d_ready), 32'(k == TIMEOUT));
      if (k == TIMEOUT) chk("timeout_d_rdata", d_rdata, 32'h0);
      half_b();
    end
    d_req = 1'b0;
    repeat (4) cycle();
    half_a();
    chk("bus_err_sticky", 32'(bus_err), 32'h1);
    half_b();

    // Asynchronous reset in the middle of a data transaction.
    do_reset();
    d_req  = 1'b1;
    d_addr = 32'h0000_0300;
    cycle();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'h0);
    chk("async_rst_d_ready", 32'(d_ready), 32'h0);
    d_req = 1'b0;
    @(negedge clk);
    chk("async_rst_no_ready", 32'(d_ready), 32'h0);
    do_reset();

    // mem_ack while idle is ignored.
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    repeat (2) cycle();
    half_a();
    chk("idle_ack_if_ready", 32'(if_ready), 32'h0);
    chk("idle_ack_d_ready", 32'(d_ready), 32'h0);
    chk("idle_ack_mem_req", 32'(mem_req), 32'h0);
    half_b();
    mem_ack = 1'b0;
    d_req   = 1'b1;
    d_addr  = 32'h0000_0400;
    cycle();
    half_a();
    chk("after_idle_ack_grant", 32'(mem_req), 32'h1);
    half_b();
    mem_ack = 1'b1;
    cycle();
    d_req   = 1'b0;
    mem_ack = 1'b0;
    cycle();

    // Randomized traffic against the model.
    do_reset();
    quiet = 0;
    for (int n = 0; n < 3000; n++) begin
      mem_ack   = (quiet == 0) && ($urandom_range(0, 99) < 35);
      mem_rdata = $urandom;
      if (quiet > 0) quiet--;
      else if ($urandom_range(0, 149) == 0) quiet = 20;
      cycle();
      if (last_ifr) begin
        if ($urandom_range(0, 1) == 0) if_req = 1'b0;
        else if_addr = $urandom;
      end else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
      if (last_dr || (!d_req && $urandom_range(0, 2) == 0)) begin
        d_req   = (last_dr) ? 1'($urandom_range(0, 1)) : 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_be    = 4'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles a memory transaction may wait for mem_ack.
REQ-002 SHALL have parameter STARVE_MAX, default 3, meaning consecutive data grants allowed while fetch waits.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port if_req  input  1  meaning a fetch request is pending; held until if_ready.
REQ-006 SHALL have port if_addr  input  32  meaning the fetch address.
REQ-007 SHALL have port if_ready  output  1  meaning a fetch-complete pulse.
REQ-008 SHALL have port if_rdata  output  32  meaning the instruction word, valid with if_ready.
REQ-009 SHALL have port d_req  input  1  meaning a load/store request is pending; held until d_ready.
REQ-010 SHALL have port d_we  input  1  meaning 1=store, 0=load.
REQ-011 SHALL have port d_be  input  4  meaning the byte enables.
REQ-012 SHALL have port d_addr  input  32  meaning the data address.
REQ-013 SHALL have port d_wdata  input  32  meaning the store data.
REQ-014 SHALL have port d_ready  output  1  meaning a data-complete pulse.
REQ-015 SHALL have port d_rdata  output  32  meaning the load data, valid with d_ready.
REQ-016 SHALL have ports mem_req  output  1, mem_we  output  1, mem_be  output  4, mem_addr  output  32, mem_wdata  output  32, forming the shared memory port, all registered.
REQ-017 SHALL have ports mem_rdata  input  32 and mem_ack  input  1, meaning memory read data and completion.
REQ-018 SHALL have port bus_err  output  1  meaning a sticky timeout flag.

Function
REQ-019 SHALL implement the states IDLE, BUSY_IF and BUSY_D.
REQ-020 In IDLE with d_req only: SHALL latch the d_* fields into mem_* on the edge and go to BUSY_D; with if_req only: SHALL latch if_addr, set mem_we=0 and mem_be=4'b1111, and go to BUSY_IF.
REQ-021 In IDLE with both requests: SHALL grant data, unless starve_cnt==STARVE_MAX, in which case SHALL grant fetch.
REQ-022 starve_cnt (2 bits): SHALL increment on a data grant while if_req=1; SHALL clear on any fetch grant; SHALL never exceed STARVE_MAX.
REQ-023 SHALL hold mem_req=1 throughout BUSY_*; mem_* fields SHALL stay stable until completion.
REQ-024 In BUSY_X with mem_ack=1: X_ready SHALL be 1 combinationally in that cycle; X_rdata SHALL equal mem_rdata; next state SHALL be IDLE; mem_req SHALL be 0 next cycle.
REQ-025 Minimum latency from request to ready SHALL be 2 cycles (grant edge, then ack cycle); back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-026 The requester SHALL drop or replace its request on the edge ending the ready cycle; the arbiter SHALL treat a request seen in IDLE as new.
REQ-027 wd_cnt SHALL clear on grant and increment each BUSY cycle without ack.
REQ-028 When wd_cnt reaches TIMEOUT-1 without ack: SHALL pulse X_ready with X_rdata=0, set bus_err, and go to IDLE.
REQ-029 bus_err SHALL clear only on reset.
REQ-030 mem_ack in IDLE SHALL be ignored, producing no ready pulse.
REQ-031 if_ready and d_ready SHALL never be 1 in the same cycle.
REQ-032 When neither ready is active, if_rdata and d_rdata SHALL be 0.

Reset
REQ-033 On reset, state SHALL be IDLE; mem_req, mem_we, bus_err, starve_cnt and wd_cnt SHALL be 0; mem_be, mem_addr and mem_wdata SHALL be 0.
REQ-034 Reset asserted mid-transaction SHALL abort it immediately, with no ready pulse.
REQ-035 After reset deasserts, the first arbitration SHALL occur on the next rising edge.

Structure
REQ-036 State encodings, TIMEOUT and STARVE_MAX defaults SHALL reside in the shared franken_defs header used by the core.
REQ-037 The watchdog counter SHALL be one sub-module, arb_watchdog (inputs clear/enable; output expired).

Verification
REQ-038 Fetch only: if_addr=0x40 and mem_ack 3 cycles after grant with mem_rdata=0x00500093 SHALL produce if_ready in the ack cycle with if_rdata=0x00500093.
REQ-039 Store: d_we=1, d_be=4'b0100, d_addr=0x102, d_wdata=0x00AB0000 SHALL drive identical mem_* fields until ack, then produce d_ready=1.
REQ-040 Simultaneous if_req and d_req held continuously SHALL produce a grant order D,D,D,IF,D,D,D,IF.
REQ-041 With mem_ack held low, a d_req SHALL produce d_ready after 16 cycles with d_rdata=0 and bus_err=1, and bus_err SHALL remain 1 afterwards.
REQ-042 reset asserted while in BUSY_D SHALL make mem_req=0 without waiting for a clock edge and produce no d_ready.
REQ-043 A mem_ack pulse while IDLE SHALL produce no ready pulse and no state change.
